reorder_buffer: RTL and testbench

In-order retirement stage directly downstream of dispatch/issue in the out-of-order RISC-V core. Accepts up to two newly dispatched instructions per cycle into a 16-entry circular buffer indexed by their ROB number. It also records completions from the three functional units (ALU0, ALU1, MEM). It retires up to two completed instructions per cycle in program order, emitting the old physical destination registers to the free list and the commit information to the architectural side.

---
 rtl/reorder_buffer_if.sv | 55 +++++
 rtl/reorder_buffer.sv | 184 ++++++++++++++++++
 tb/tb_reorder_buffer.sv | 430 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reorder_buffer_if.sv
// Shared ROB types and the dispatch / functional-unit / retire bundle.
// The master side (dispatch, FUs, consumers) drives the i_* signals;
// the slave side (the reorder buffer) drives the o_* signals.

package rob_pkg;
    localparam int ROB_DEPTH = 16;
    localparam int ROB_IDX_W = 4;

    typedef logic [31:0]          word;
    typedef logic [5:0]           p_reg;
    typedef logic [ROB_IDX_W-1:0] rob_num;

    typedef struct packed {
        logic   valid;
        rob_num rob_number;
        p_reg   preg_addr_dst;
        p_reg   old_preg_addr_dst;
        logic   regwrite;
        logic   memwrite;
    } rob_row_struct;
endpackage

interface reorder_buffer_if;
    import rob_pkg::*;

    // Allocation lanes from dispatch, lane 0 is older
    rob_row_struct i_rob_rows        [0:1];
    // Completion reports from ALU0, ALU1, MEM
    logic          i_complete_valid  [0:2];
    rob_num        i_complete_rob    [0:2];
    word           i_complete_data   [0:2];
    // Occupancy
    logic          o_full;
    logic [4:0]    o_count;
    // Retire lanes, lane 0 is older
    logic          o_retire_valid    [0:1];
    p_reg          o_retire_dst      [0:1];
    p_reg          o_retire_old_dst  [0:1];
    word           o_retire_data     [0:1];
    logic          o_retire_regwrite [0:1];
    logic          o_retire_memwrite [0:1];
    logic          o_alloc_err;

    modport master (
        output i_rob_rows, i_complete_valid, i_complete_rob, i_complete_data,
        input  o_full, o_count, o_retire_valid, o_retire_dst, o_retire_old_dst,
               o_retire_data, o_retire_regwrite, o_retire_memwrite, o_alloc_err
    );

    modport slave (
        input  i_rob_rows, i_complete_valid, i_complete_rob, i_complete_data,
        output o_full, o_count, o_retire_valid, o_retire_dst, o_retire_old_dst,
               o_retire_data, o_retire_regwrite, o_retire_memwrite, o_alloc_err
    );
endinterface

// File: rtl/reorder_buffer.sv
// reorder_buffer: 16-entry in-order retirement stage.
// Entries are indexed by the ROB number dispatch assigns; up to two are
// allocated per cycle, three FUs report completions, and the oldest
// completed entries retire in program order with registered outputs.
// Define ROB_DUAL_RETIRE_EN to retire up to two entries per cycle;
// without it only lane 0 retires and every lane-1 output stays 0.

module reorder_buffer
    import rob_pkg::*;
(
    input  logic            i_clk,
    input  logic            i_rst,
    reorder_buffer_if.slave rob
);

    localparam int DEPTH = ROB_DEPTH;

    // Entry control state
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [DEPTH-1:0] complete_q, complete_d;
    // Entry payload
    p_reg             dst_q      [DEPTH];
    p_reg             old_dst_q  [DEPTH];
    word              data_q     [DEPTH];
    logic [DEPTH-1:0] regwrite_q;
    logic [DEPTH-1:0] memwrite_q;

    rob_num           head_q, head_d, head1;
    logic [4:0]       count_q, count_d;
    logic             alloc_err_q, alloc_err_d;

    // Registered retire outputs
    logic             ret_valid_q    [0:1];
    p_reg             ret_dst_q      [0:1];
    p_reg             ret_old_dst_q  [0:1];
    word              ret_data_q     [0:1];
    logic             ret_regwrite_q [0:1];
    logic             ret_memwrite_q [0:1];

    rob_row_struct    row0, row1;
    logic [1:0]       alloc_ok;
    logic             alloc_bad;
    logic             ret0, ret1;
    logic [1:0]       n_alloc, n_ret;

    assign row0 = rob.i_rob_rows[0];
    assign row1 = rob.i_rob_rows[1];

    // A lane allocates only into a free entry; lane 1 aimed at the same
    // index lane 0 just claimed counts as hitting an occupied entry.
    assign alloc_ok[0] = row0.valid && !valid_q[row0.rob_number];
    assign alloc_ok[1] = row1.valid && !valid_q[row1.rob_number]
                      && !(alloc_ok[0] && (row0.rob_number == row1.rob_number));
    assign alloc_bad   = (row0.valid && !alloc_ok[0]) || (row1.valid && !alloc_ok[1]);

    // Retire decisions look only at pre-edge state: no completion bypass.
    assign head1 = head_q + rob_num'(1);
    assign ret0  = valid_q[head_q] && complete_q[head_q];
`ifdef ROB_DUAL_RETIRE_EN
    assign ret1  = ret0 && valid_q[head1] && complete_q[head1];
`else
    assign ret1  = 1'b0;
`endif

    assign n_alloc = {1'b0, alloc_ok[0]} + {1'b0, alloc_ok[1]};
    assign n_ret   = {1'b0, ret0} + {1'b0, ret1};

    // Next-state of entry flags, head, count and the sticky error
    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        valid_d     = valid_q;
        complete_d  = complete_q;
        head_d      = head_q + rob_num'(n_ret);
        count_d     = count_q + 5'(n_alloc) - 5'(n_ret);
        alloc_err_d = alloc_err_q || alloc_bad;

        for (int k = 0; k < 3; k++) begin
            if (rob.i_complete_valid[k] && valid_q[rob.i_complete_rob[k]]) begin
                complete_d[rob.i_complete_rob[k]] = 1'b1;
            end
        end

        if (ret0) begin
            valid_d[head_q]    = 1'b0;
            complete_d[head_q] = 1'b0;
        end
        if (ret1) begin
            valid_d[head1]    = 1'b0;
            complete_d[head1] = 1'b0;
        end

        // Allocation targets are free pre-edge, so a same-cycle completion
        // to them was already rejected above; allocation clears complete.
        if (alloc_ok[0]) begin
            valid_d[row0.rob_number]    = 1'b1;
            complete_d[row0.rob_number] = 1'b0;
        end
        if (alloc_ok[1]) begin
            valid_d[row1.rob_number]    = 1'b1;
            complete_d[row1.rob_number] = 1'b0;
        end
    end

    // Control state and registered retire outputs, synchronous reset
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            valid_q     <= '0;
            complete_q  <= '0;
            head_q      <= '0;
            count_q     <= '0;
            alloc_err_q <= 1'b0;
            for (int l = 0; l < 2; l++) begin
                ret_valid_q[l]    <= 1'b0;
                ret_dst_q[l]      <= '0;
                ret_old_dst_q[l]  <= '0;
                ret_data_q[l]     <= '0;
                ret_regwrite_q[l] <= 1'b0;
                ret_memwrite_q[l] <= 1'b0;
            end
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every
            // register samples the pre-edge values computed above.
            valid_q     <= valid_d;
            complete_q  <= complete_d;
            head_q      <= head_d;
            count_q     <= count_d;
            alloc_err_q <= alloc_err_d;

            ret_valid_q[0]    <= ret0;
            ret_dst_q[0]      <= ret0 ? dst_q[head_q]      : '0;
            ret_old_dst_q[0]  <= ret0 ? old_dst_q[head_q]  : '0;
            ret_data_q[0]     <= ret0 ? data_q[head_q]     : '0;
            ret_regwrite_q[0] <= ret0 && regwrite_q[head_q];
            ret_memwrite_q[0] <= ret0 && memwrite_q[head_q];

            ret_valid_q[1]    <= ret1;
            ret_dst_q[1]      <= ret1 ? dst_q[head1]       : '0;
            ret_old_dst_q[1]  <= ret1 ? old_dst_q[head1]   : '0;
            ret_data_q[1]     <= ret1 ? data_q[head1]      : '0;
            ret_regwrite_q[1] <= ret1 && regwrite_q[head1];
            ret_memwrite_q[1] <= ret1 && memwrite_q[head1];
        end
    end

    // Entry payload storage; completions in FU order so the highest k wins
    // NOTE: payload is not reset; it is never observed unless valid/complete are set.
    always_ff @(posedge i_clk) begin
        for (int k = 0; k < 3; k++) begin
            if (rob.i_complete_valid[k] && valid_q[rob.i_complete_rob[k]]) begin
                data_q[rob.i_complete_rob[k]] <= rob.i_complete_data[k];
            end
        end
        if (alloc_ok[0]) begin
            dst_q[row0.rob_number]      <= row0.preg_addr_dst;
            old_dst_q[row0.rob_number]  <= row0.old_preg_addr_dst;
            regwrite_q[row0.rob_number] <= row0.regwrite;
            memwrite_q[row0.rob_number] <= row0.memwrite;
        end
        if (alloc_ok[1]) begin
            dst_q[row1.rob_number]      <= row1.preg_addr_dst;
            old_dst_q[row1.rob_number]  <= row1.old_preg_addr_dst;
            regwrite_q[row1.rob_number] <= row1.regwrite;
            memwrite_q[row1.rob_number] <= row1.memwrite;
        end
    end

    assign rob.o_count     = count_q;
    assign rob.o_full      = (count_q >= 5'(DEPTH - 1));
    assign rob.o_alloc_err = alloc_err_q;

    assign rob.o_retire_valid[0]    = ret_valid_q[0];
    assign rob.o_retire_valid[1]    = ret_valid_q[1];
    assign rob.o_retire_dst[0]      = ret_dst_q[0];
    assign rob.o_retire_dst[1]      = ret_dst_q[1];
    assign rob.o_retire_old_dst[0]  = ret_old_dst_q[0];
    assign rob.o_retire_old_dst[1]  = ret_old_dst_q[1];
    assign rob.o_retire_data[0]     = ret_data_q[0];
    assign rob.o_retire_data[1]     = ret_data_q[1];
    assign rob.o_retire_regwrite[0] = ret_regwrite_q[0];
    assign rob.o_retire_regwrite[1] = ret_regwrite_q[1];
    assign rob.o_retire_memwrite[0] = ret_memwrite_q[0];
    assign rob.o_retire_memwrite[1] = ret_memwrite_q[1];

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer. Every accepted allocation pushes
// its expected retire record onto a scoreboard queue; retire outputs are
// popped and compared one cycle-step later. Expectations follow whether
// ROB_DUAL_RETIRE_EN is defined for the build.

module tb_reorder_buffer;
    import rob_pkg::*;

`ifdef ROB_DUAL_RETIRE_EN
    localparam bit DUAL = 1'b1;
`else
    localparam bit DUAL = 1'b0;
`endif

    typedef struct packed {
        rob_num num;
        p_reg   dst;
        p_reg   old;
        logic   rw;
        logic   mw;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    reorder_buffer_if rob_if ();

    reorder_buffer dut (
        .i_clk (clk),
        .i_rst (rst),
        .rob   (rob_if)
    );

    exp_t sb_q[$];
    word  exp_data [16];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [1:0] rv2();
        return {rob_if.o_retire_valid[1], rob_if.o_retire_valid[0]};
    endfunction

    task automatic clear_inputs();
        rob_row_struct idle;
        idle = '0;
        for (int l = 0; l < 2; l++) rob_if.i_rob_rows[l] = idle;
        for (int k = 0; k < 3; k++) begin
            rob_if.i_complete_valid[k] = 1'b0;
            rob_if.i_complete_rob[k]   = '0;
            rob_if.i_complete_data[k]  = '0;
        end
    endtask

    // Pop and compare whatever retired at the last edge
    task automatic scoreboard_retire();
        exp_t        e;
        logic [45:0] got, want;
        for (int l = 0; l < 2; l++) begin
            if (rob_if.o_retire_valid[l]) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL retire_unexpected: lane %0d retired dst=%0d, scoreboard empty",
                             l, rob_if.o_retire_dst[l]);
                end else begin
                    e    = sb_q.pop_front();
                    got  = {rob_if.o_retire_dst[l], rob_if.o_retire_old_dst[l],
                            rob_if.o_retire_regwrite[l], rob_if.o_retire_memwrite[l],
                            rob_if.o_retire_data[l]};
                    want = {e.dst, e.old, e.rw, e.mw, exp_data[e.num]};
                    if (got !== want) begin
                        errors++;
                        $display("FAIL retire_lane%0d rob%0d: got dst=%0d old=%0d rw=%0b mw=%0b data=%h, want dst=%0d old=%0d rw=%0b mw=%0b data=%h",
                                 l, e.num, got[45:40], got[39:34], got[33], got[32], got[31:0],
                                 want[45:40], want[39:34], want[33], want[32], want[31:0]);
                    end
                end
            end
        end
        if (rob_if.o_retire_valid[1]) begin
            checks++;
            if (!rob_if.o_retire_valid[0] || !DUAL) begin
                errors++;
                $display("FAIL lane1_rule: got valid={%0b,%0b}, lane1 needs lane0 and dual retire",
                         rob_if.o_retire_valid[1], rob_if.o_retire_valid[0]);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (!rst) scoreboard_retire();
        clear_inputs();
    endtask

    task automatic drive_alloc(input int lane, input int num, input int dst, input int old,
                               input bit push);
        rob_row_struct row;
        exp_t          e;
        row.valid             = 1'b1;
        row.rob_number        = rob_num'(num);
        row.preg_addr_dst     = p_reg'(dst);
        row.old_preg_addr_dst = p_reg'(old);
        row.regwrite          = ~num[0];
        row.memwrite          = num[0];
        rob_if.i_rob_rows[lane] = row;
        if (push) begin
            e = '{num: row.rob_number, dst: row.preg_addr_dst, old: row.old_preg_addr_dst,
                  rw: row.regwrite, mw: row.memwrite};
            sb_q.push_back(e);
        end
    endtask

    task automatic drive_complete(input int fu, input int num, input word data, input bit takes);
        rob_if.i_complete_valid[fu] = 1'b1;
        rob_if.i_complete_rob[fu]   = rob_num'(num);
        rob_if.i_complete_data[fu]  = data;
        if (takes) exp_data[num] = data;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        sb_q.delete();
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic wait_empty(input string name, input int budget);
        int n = 0;
        while (rob_if.o_count != 5'd0 && n < budget) begin
            step();
            n++;
        end
        checks++;
        if (rob_if.o_count !== 5'd0) begin
            errors++;
            $display("FAIL %s_drain: got count=%0d after %0d cycles, want 0", name, rob_if.o_count, budget);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({rob_if.o_count, rob_if.o_full, rob_if.o_alloc_err, rv2()} !== 9'd0) begin
            errors++;
            $display("FAIL reset_state: got count=%0d full=%0b err=%0b rv=%b, want all 0",
                     rob_if.o_count, rob_if.o_full, rob_if.o_alloc_err, rv2());
        end
        checks++;
        if ({rob_if.o_retire_dst[0], rob_if.o_retire_old_dst[1], rob_if.o_retire_data[0],
             rob_if.o_retire_data[1]} !== '0) begin
            errors++;
            $display("FAIL reset_retire_fields: got dst0=%0d old1=%0d data0=%h data1=%h, want 0",
                     rob_if.o_retire_dst[0], rob_if.o_retire_old_dst[1],
                     rob_if.o_retire_data[0], rob_if.o_retire_data[1]);
        end
    endtask

    task automatic test_pair_retire();
        do_reset();
        drive_alloc(0, 0, 33, 5, 1'b1);
        drive_alloc(1, 1, 34, 6, 1'b1);
        step();
        checks++;
        if (rob_if.o_count !== 5'd2) begin
            errors++; $display("FAIL pair_count_alloc: got %0d want 2", rob_if.o_count);
        end
        drive_complete(0, 1, 32'hDEAD_BEEF, 1'b1);
        step();
        checks++;
        if (rv2() !== 2'b00) begin
            errors++; $display("FAIL pair_early_retire1: got rv=%b want 00", rv2());
        end
        drive_complete(1, 0, 32'h1, 1'b1);
        step();
        checks++;
        if (rv2() !== 2'b00 || rob_if.o_count !== 5'd2) begin
            errors++; $display("FAIL pair_early_retire2: got rv=%b count=%0d want rv=00 count=2", rv2(), rob_if.o_count);
        end
        step();
`ifdef ROB_DUAL_RETIRE_EN
        checks++;
        if (rv2() !== 2'b11 || rob_if.o_retire_old_dst[0] !== p_reg'(5) ||
            rob_if.o_retire_old_dst[1] !== p_reg'(6) || rob_if.o_retire_data[1] !== 32'hDEAD_BEEF ||
            rob_if.o_count !== 5'd0) begin
            errors++;
            $display("FAIL pair_dual: got rv=%b old0=%0d old1=%0d data1=%h count=%0d want rv=11 old0=5 old1=6 data1=deadbeef count=0",
                     rv2(), rob_if.o_retire_old_dst[0], rob_if.o_retire_old_dst[1],
                     rob_if.o_retire_data[1], rob_if.o_count);
        end
`else
        checks++;
        if (rv2() !== 2'b01 || rob_if.o_retire_old_dst[0] !== p_reg'(5) || rob_if.o_count !== 5'd1) begin
            errors++;
            $display("FAIL pair_single0: got rv=%b old0=%0d count=%0d want rv=01 old0=5 count=1",
                     rv2(), rob_if.o_retire_old_dst[0], rob_if.o_count);
        end
        step();
        checks++;
        if (rv2() !== 2'b01 || rob_if.o_retire_old_dst[0] !== p_reg'(6) ||
            rob_if.o_retire_data[0] !== 32'hDEAD_BEEF || rob_if.o_count !== 5'd0) begin
            errors++;
            $display("FAIL pair_single1: got rv=%b old0=%0d data0=%h count=%0d want rv=01 old0=6 data0=deadbeef count=0",
                     rv2(), rob_if.o_retire_old_dst[0], rob_if.o_retire_data[0], rob_if.o_count);
        end
`endif
        step();
        checks++;
        if (rv2() !== 2'b00) begin
            errors++; $display("FAIL pair_one_cycle_pulse: got rv=%b want 00", rv2());
        end
    endtask

    task automatic test_fill_full();
        int per = DUAL ? 2 : 1;
        do_reset();
        for (int i = 0; i < 7; i++) begin
            drive_alloc(0, 2 * i, 32 + 2 * i, 2 * i + 1, 1'b1);
            drive_alloc(1, 2 * i + 1, 33 + 2 * i, 2 * i + 2, 1'b1);
            step();
            checks++;
            if (rob_if.o_count !== 5'(2 * i + 2) || rob_if.o_full !== 1'b0 || rv2() !== 2'b00) begin
                errors++;
                $display("FAIL fill_step%0d: got count=%0d full=%0b rv=%b want count=%0d full=0 rv=00",
                         i, rob_if.o_count, rob_if.o_full, rv2(), 2 * i + 2);
            end
        end
        for (int n = 14; n < 16; n++) begin
            drive_alloc(0, n, 32 + n, n + 1, 1'b1);
            step();
            checks++;
            if (rob_if.o_count !== 5'(n + 1) || rob_if.o_full !== 1'b1) begin
                errors++;
                $display("FAIL fill_full%0d: got count=%0d full=%0b want count=%0d full=1",
                         n + 1, rob_if.o_count, rob_if.o_full, n + 1);
            end
        end
        // Complete youngest first so nothing may retire until ROB 0 is done
        for (int c = 0; c < 6; c++) begin
            for (int k = 0; k < 3; k++) begin
                if (15 - 3 * c - k >= 0)
                    drive_complete(k, 15 - 3 * c - k, 32'h100 + 32'(15 - 3 * c - k), 1'b1);
            end
            step();
            checks++;
            if (rv2() !== 2'b00 || rob_if.o_count !== 5'd16) begin
                errors++;
                $display("FAIL fill_hold%0d: got rv=%b count=%0d want rv=00 count=16", c, rv2(), rob_if.o_count);
            end
        end
        for (int c = 0; c < 16 / per; c++) begin
            step();
            checks++;
            if (rv2() !== (DUAL ? 2'b11 : 2'b01) || rob_if.o_count !== 5'(16 - (c + 1) * per)) begin
                errors++;
                $display("FAIL fill_drain%0d: got rv=%b count=%0d want rv=%b count=%0d",
                         c, rv2(), rob_if.o_count, (DUAL ? 2'b11 : 2'b01), 16 - (c + 1) * per);
            end
        end
        step();
        checks++;
        if (rv2() !== 2'b00 || rob_if.o_full !== 1'b0) begin
            errors++; $display("FAIL fill_empty: got rv=%b full=%0b want rv=00 full=0", rv2(), rob_if.o_full);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 7; i++) begin
            drive_alloc(0, 2 * i, 32 + 2 * i, 2 * i + 1, 1'b1);
            drive_alloc(1, 2 * i + 1, 33 + 2 * i, 2 * i + 2, 1'b1);
            step();
        end
        drive_alloc(0, 14, 46, 15, 1'b1);
        step();
        for (int c = 0; c < 5; c++) begin
            for (int k = 0; k < 3; k++) drive_complete(k, 3 * c + k, 32'h200 + 32'(3 * c + k), 1'b1);
            step();
        end
        wait_empty("wrap_pre", 40);
        // Head now sits at 15
        drive_alloc(0, 15, 60, 20, 1'b1);
        drive_alloc(1, 0, 61, 21, 1'b1);
        step();
        drive_complete(0, 15, 32'hF15, 1'b1);
        drive_complete(1, 0, 32'hF00, 1'b1);
        step();
        step();
        checks++;
        if (rv2() !== (DUAL ? 2'b11 : 2'b01) || rob_if.o_retire_dst[0] !== p_reg'(60) ||
            rob_if.o_retire_dst[1] !== (DUAL ? p_reg'(61) : p_reg'(0))) begin
            errors++;
            $display("FAIL wrap_retire: got rv=%b dst0=%0d dst1=%0d", rv2(),
                     rob_if.o_retire_dst[0], rob_if.o_retire_dst[1]);
        end
        wait_empty("wrap", 4);
        // Head must now be 1: an entry at index 1 retires
        drive_alloc(0, 1, 62, 22, 1'b1);
        step();
        drive_complete(2, 1, 32'hA11, 1'b1);
        step();
        step();
        checks++;
        if (rv2() !== 2'b01 || rob_if.o_retire_dst[0] !== p_reg'(62)) begin
            errors++;
            $display("FAIL wrap_head1: got rv=%b dst0=%0d want rv=01 dst0=62", rv2(), rob_if.o_retire_dst[0]);
        end
    endtask

    task automatic test_same_cycle();
        int n = 0;
        do_reset();
        drive_alloc(0, 0, 40, 1, 1'b1);
        drive_alloc(1, 1, 41, 2, 1'b1);
        step();
        drive_alloc(0, 2, 42, 3, 1'b1);
        step();
        drive_alloc(0, 3, 43, 4, 1'b1);
        drive_alloc(1, 4, 44, 5, 1'b1);
        drive_complete(1, 3, 32'h77, 1'b0);
        step();
        checks++;
        if (rob_if.o_count !== 5'd5) begin
            errors++; $display("FAIL same_alloc_count: got %0d want 5", rob_if.o_count);
        end
        drive_complete(0, 4, 32'hA, 1'b1);
        drive_complete(2, 4, 32'hB, 1'b1);
        drive_complete(1, 0, 32'h10, 1'b1);
        step();
        drive_complete(0, 1, 32'h11, 1'b1);
        drive_complete(1, 2, 32'h12, 1'b1);
        step();
        while (rob_if.o_count != 5'd2 && n < 10) begin
            step();
            n++;
        end
        step();
        step();
        checks++;
        if (rob_if.o_count !== 5'd2 || rv2() !== 2'b00) begin
            errors++;
            $display("FAIL same_alloc_wins: got count=%0d rv=%b want count=2 rv=00 (ROB 3 not complete)",
                     rob_if.o_count, rv2());
        end
        drive_complete(0, 3, 32'h33, 1'b1);
        step();
        wait_empty("same", 6);
    endtask

    task automatic test_alloc_err_and_reset();
        do_reset();
        drive_alloc(0, 0, 40, 7, 1'b1);
        drive_alloc(1, 1, 41, 8, 1'b1);
        step();
        drive_alloc(0, 0, 50, 9, 1'b0);
        step();
        checks++;
        if (rob_if.o_alloc_err !== 1'b1 || rob_if.o_count !== 5'd2) begin
            errors++;
            $display("FAIL err_set: got err=%0b count=%0d want err=1 count=2", rob_if.o_alloc_err, rob_if.o_count);
        end
        drive_alloc(0, 2, 42, 10, 1'b1);
        drive_alloc(1, 3, 43, 11, 1'b1);
        step();
        drive_complete(0, 0, 32'h55, 1'b1);
        step();
        step();
        checks++;
        if (rv2() !== 2'b01 || rob_if.o_retire_old_dst[0] !== p_reg'(7) || rob_if.o_retire_dst[0] !== p_reg'(40)) begin
            errors++;
            $display("FAIL err_orig_kept: got rv=%b dst0=%0d old0=%0d want rv=01 dst0=40 old0=7",
                     rv2(), rob_if.o_retire_dst[0], rob_if.o_retire_old_dst[0]);
        end
        drive_alloc(0, 4, 44, 12, 1'b1);
        drive_alloc(1, 5, 45, 13, 1'b1);
        step();
        checks++;
        if (rob_if.o_count !== 5'd5 || rob_if.o_alloc_err !== 1'b1) begin
            errors++;
            $display("FAIL err_sticky: got count=%0d err=%0b want count=5 err=1", rob_if.o_count, rob_if.o_alloc_err);
        end
        drive_complete(1, 1, 32'h66, 1'b1);
        step();
        // ROB 1 would retire at this edge; reset discards it
        rst = 1'b1;
        sb_q.delete();
        step();
        checks++;
        if (rob_if.o_count !== 5'd0 || rv2() !== 2'b00 || rob_if.o_alloc_err !== 1'b0 || rob_if.o_full !== 1'b0) begin
            errors++;
            $display("FAIL midrun_reset: got count=%0d rv=%b err=%0b full=%0b want all 0",
                     rob_if.o_count, rv2(), rob_if.o_alloc_err, rob_if.o_full);
        end
        rst = 1'b0;
        step();
        checks++;
        if (rob_if.o_count !== 5'd0 || rv2() !== 2'b00) begin
            errors++;
            $display("FAIL post_reset_idle: got count=%0d rv=%b want count=0 rv=00", rob_if.o_count, rv2());
        end
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_pair_retire();
        test_fill_full();
        test_wrap();
        test_same_cycle();
        test_alloc_err_and_reset();
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover: got %0d pending retirements want 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
